// File: rtl/frame_sender_if.sv
// rtl/frame_sender_if.sv - MAC TX client byte interface between frame_sender and the MAC
interface frame_sender_if;
  logic [7:0] mac_tx_data;
  logic       mac_tx_dvld;
  logic       mac_tx_ack;

  modport master (output mac_tx_data, output mac_tx_dvld, input mac_tx_ack);
  modport slave  (input mac_tx_data, input mac_tx_dvld, output mac_tx_ack);
endinterface

// File: rtl/frame_sender.sv
// rtl/frame_sender.sv - builds sequence/timestamp test frames and drives them into the MAC TX client
module frame_sender #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0002_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          ACK_TIMEOUT = 1023
) (
  input  logic         tx_clk,
  input  logic         reset_n,
  output logic         conf_tx_en,
  output logic         conf_tx_no_gen_crc,
  output logic         conf_tx_jumbo_en,
  input  logic         start,
  input  logic         continuous,
  input  logic [13:0]  frame_len,
  input  logic [15:0]  gap_len,
  frame_sender_if.master mac,
  output logic         busy,
  output logic         sent_pulse,
  output logic [31:0]  sent_timestamp,
  output logic [31:0]  frame_count,
  output logic         abort_pulse
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DATA, GAP} state_t;

  state_t      state;
  logic [31:0] ts_cnt;
  logic [31:0] ts_latched;
  logic [31:0] seq_num;
  logic [13:0] byte_idx;
  logic [13:0] eff_len;
  logic [15:0] wait_cnt;
  logic [15:0] gap_cnt;

  assign conf_tx_en         = 1'b1;
  assign conf_tx_no_gen_crc = 1'b0;
  assign conf_tx_jumbo_en   = 1'b0;
  assign busy               = (state != IDLE);

  // Clamp the requested length to the legal untagged Ethernet range (FCS excluded).
  function automatic logic [13:0] clamp_len(input logic [13:0] fl);
    if (fl < 14'd60)
      clamp_len = 14'd60;
    else if (fl > 14'd1514)
      clamp_len = 14'd1514;
    else
      clamp_len = fl;
  endfunction

  // Header bytes come from one 22-byte image shifted by the index; payload is the index itself.
  function automatic logic [7:0] byte_at(input logic [13:0] i, input logic [31:0] seq_v,
                                         input logic [31:0] ts_v);
    logic [175:0] hdr;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq_v, ts_v} << {i[4:0], 3'b000};
    if (i < 14'd22)
      byte_at = hdr[175:168];
    else
      byte_at = i[7:0];
  endfunction

  // Free-running transmit timestamp.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n)
      ts_cnt <= 32'd0;
    else
      ts_cnt <= ts_cnt + 32'd1;
  end

  // Frame sequencer: waits for ack, streams the frame, then idles or gaps before the next one.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      mac.mac_tx_data <= 8'd0;
      mac.mac_tx_dvld <= 1'b0;
      byte_idx        <= 14'd0;
      eff_len         <= 14'd60;
      wait_cnt        <= 16'd0;
      gap_cnt         <= 16'd0;
      seq_num         <= 32'd0;
      ts_latched      <= 32'd0;
      sent_timestamp  <= 32'd0;
      frame_count     <= 32'd0;
      sent_pulse      <= 1'b0;
      abort_pulse     <= 1'b0;
    end else begin
      sent_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start || continuous) begin
            eff_len         <= clamp_len(frame_len);
            mac.mac_tx_dvld <= 1'b1;
            mac.mac_tx_data <= DST_MAC[47:40];
            wait_cnt        <= 16'd0;
            state           <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mac.mac_tx_ack) begin
            ts_latched      <= ts_cnt;
            byte_idx        <= 14'd1;
            mac.mac_tx_data <= byte_at(14'd1, seq_num, ts_cnt);
            state           <= DATA;
          end else if (wait_cnt == 16'(ACK_TIMEOUT - 1)) begin
            mac.mac_tx_dvld <= 1'b0;
            mac.mac_tx_data <= 8'd0;
            abort_pulse     <= 1'b1;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DATA: begin
          if (byte_idx == eff_len - 14'd1) begin
            mac.mac_tx_dvld <= 1'b0;
            mac.mac_tx_data <= 8'd0;
            sent_pulse      <= 1'b1;
            sent_timestamp  <= ts_latched;
            seq_num         <= seq_num + 32'd1;
            frame_count     <= frame_count + 32'd1;
            gap_cnt         <= 16'd0;
            state           <= continuous ? GAP : IDLE;
          end else begin
            byte_idx        <= byte_idx + 14'd1;
            mac.mac_tx_data <= byte_at(byte_idx + 14'd1, seq_num, ts_latched);
          end
        end
        GAP: begin
          // The first GAP cycle is the mandatory dvld-low cycle, so gap_len 0 and 1 behave alike.
          if (({1'b0, gap_cnt} + 17'd1) >= {1'b0, gap_len}) begin
            if (continuous) begin
              eff_len         <= clamp_len(frame_len);
              mac.mac_tx_dvld <= 1'b1;
              mac.mac_tx_data <= DST_MAC[47:40];
              wait_cnt        <= 16'd0;
              state           <= WAIT_ACK;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sender.sv
// tb/tb_frame_sender.sv - self-checking bench for frame_sender
module tb_frame_sender;
  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0002_0000_0001;
  localparam logic [15:0] ETY = 16'h88B5;

  logic        tx_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [13:0] frame_len = 14'd64;
  logic [15:0] gap_len = 16'd0;
  logic        conf_tx_en, conf_tx_no_gen_crc, conf_tx_jumbo_en;
  logic        busy, sent_pulse, abort_pulse;
  logic [31:0] sent_timestamp, frame_count;

  frame_sender_if mac();

  frame_sender dut (
    .tx_clk             (tx_clk),
    .reset_n            (reset_n),
    .conf_tx_en         (conf_tx_en),
    .conf_tx_no_gen_crc (conf_tx_no_gen_crc),
    .conf_tx_jumbo_en   (conf_tx_jumbo_en),
    .start              (start),
    .continuous         (continuous),
    .frame_len          (frame_len),
    .gap_len            (gap_len),
    .mac                (mac),
    .busy               (busy),
    .sent_pulse         (sent_pulse),
    .sent_timestamp     (sent_timestamp),
    .frame_count        (frame_count),
    .abort_pulse        (abort_pulse)
  );

  always #5 tx_clk = ~tx_clk;

  // Reference time: rising edges since reset release.
  logic [31:0] cyc = 32'd0;
  always @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) cyc <= 32'd0;
    else          cyc <= cyc + 32'd1;
  end

  int passed = 0;
  int total = 0;
  int failed = 0;
  int ack_delay = 3;
  int nfr = 0;
  int cur_len = 0;
  int n_sent = 0;
  int n_abort = 0;
  int last_dvc = 0;
  logic [31:0] exp_seq = 32'd0;
  logic [31:0] exp_fc = 32'd0;

  logic [7:0]  fbuf [0:3][0:1599];
  int          flen [0:3];
  logic [31:0] fts [0:3];
  int          fdvc [0:3];
  int          fgap [0:3];
  int          fhold [0:3];

  // MAC model: acks after ack_delay dvld cycles (0 = never) and captures accepted bytes.
  initial begin
    bit prev, acked, have_fall;
    int wait_n, dvc, herr, gap_cur, k;
    logic [31:0] ts_cur, last_fall;
    prev = 0; acked = 0; have_fall = 0; wait_n = 0; dvc = 0; herr = 0; gap_cur = -1;
    ts_cur = 0; last_fall = 0;
    mac.mac_tx_ack = 1'b0;
    forever begin
      @(negedge tx_clk);
      if (!reset_n) begin
        prev = 0; acked = 0; have_fall = 0; cur_len = 0;
        mac.mac_tx_ack = 1'b0;
        continue;
      end
      mac.mac_tx_ack = 1'b0;
      if (sent_pulse) n_sent++;
      if (abort_pulse) n_abort++;
      k = nfr % 4;
      if (mac.mac_tx_dvld) begin
        if (!prev) begin
          acked = 0; wait_n = 0; dvc = 0; herr = 0; cur_len = 0;
          gap_cur = have_fall ? int'(cyc - last_fall) : -1;
        end
        dvc++;
        if (acked) begin
          if (cur_len < 1600) fbuf[k][cur_len] = mac.mac_tx_data;
          cur_len++;
        end else begin
          wait_n++;
          if (mac.mac_tx_data !== 8'hFF) herr++;
          if (wait_n == ack_delay) begin
            mac.mac_tx_ack = 1'b1;
            ts_cur = cyc;
            acked = 1;
            fbuf[k][0] = mac.mac_tx_data;
            cur_len = 1;
          end
        end
      end else if (prev) begin
        last_dvc = dvc; last_fall = cyc; have_fall = 1;
        if (acked) begin
          flen[k] = cur_len; fts[k] = ts_cur; fdvc[k] = dvc; fgap[k] = gap_cur; fhold[k] = herr;
          nfr++;
        end
      end
      prev = mac.mac_tx_dvld;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge tx_clk);
  endtask

  function automatic int eff(input int fl);
    return (fl < 60) ? 60 : ((fl > 1514) ? 1514 : fl);
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] seq, input logic [31:0] ts);
    if (i < 6)       return 8'(DST >> (8 * (5 - i)));
    else if (i < 12) return 8'(SRC >> (8 * (11 - i)));
    else if (i < 14) return 8'(ETY >> (8 * (13 - i)));
    else if (i < 18) return 8'(seq >> (8 * (17 - i)));
    else if (i < 22) return 8'(ts >> (8 * (21 - i)));
    else             return 8'(i % 256);
  endfunction

  task automatic check_frame(input int k, input int fl, input logic [31:0] seq, input int ad,
                             input string tag);
    int s, l, errs;
    s = k % 4; l = eff(fl); errs = 0;
    chk({tag, "_len"}, 64'(flen[s]), 64'(l));
    for (int i = 0; i < l && i < 1600; i++)
      if (fbuf[s][i] !== exp_byte(i, seq, fts[s])) errs++;
    chk({tag, "_bytes"}, 64'(errs), 64'd0);
    chk({tag, "_dvld_cycles"}, 64'(fdvc[s]), 64'(ad + l - 1));
    chk({tag, "_byte0_hold"}, 64'(fhold[s]), 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    int bud;
    bud = 0;
    while (busy && bud < 5000) begin @(negedge tx_clk); bud++; end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int bud;
    bud = 0;
    while (nfr < target && bud < 8000) begin @(negedge tx_clk); bud++; end
    chk({tag, "_done"}, 64'(nfr >= target), 64'd1);
  endtask

  task automatic pulse_start();
    @(negedge tx_clk); start = 1'b1;
    @(negedge tx_clk); start = 1'b0;
  endtask

  // Waits for the next dvld rise and one more cycle so the capture state is fresh.
  task automatic wait_rise(input string tag);
    int bud;
    bud = 0;
    while (!mac.mac_tx_dvld && bud < 2000) begin @(negedge tx_clk); bud++; end
    chk({tag, "_rise"}, 64'(mac.mac_tx_dvld), 64'd1);
    @(negedge tx_clk);
  endtask

  task automatic wait_bytes(input int n);
    int bud;
    bud = 0;
    while (cur_len < n && bud < 3000) begin @(negedge tx_clk); bud++; end
  endtask

  task automatic run_single(input int fl, input int ad, input string tag);
    int base, ns;
    base = nfr; ns = n_sent;
    frame_len = 14'(fl); ack_delay = ad;
    pulse_start();
    wait_frames(base + 1, tag);
    tick(3);
    check_frame(base, fl, exp_seq, ad, tag);
    exp_seq++; exp_fc++;
    chk({tag, "_frame_count"}, 64'(frame_count), 64'(exp_fc));
    chk({tag, "_sent_ts"}, 64'(sent_timestamp), 64'(fts[base % 4]));
    chk({tag, "_sent_pulses"}, 64'(n_sent - ns), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int base, na, fl, ad;

    // Reset state.
    tick(3);
    chk("reset_conf", {61'd0, conf_tx_en, conf_tx_no_gen_crc, conf_tx_jumbo_en}, 64'b100);
    chk("reset_flags", {60'd0, mac.mac_tx_dvld, busy, sent_pulse, abort_pulse}, 64'd0);
    chk("reset_counts", {sent_timestamp, frame_count}, 64'd0);
    reset_n = 1'b1;
    tick(2);

    // Single 64-byte frame, ack on the third dvld cycle.
    run_single(64, 3, "f64");

    // Length clamping at both ends.
    run_single(10, 2, "f10");
    run_single(2000, 1, "f2000");
    chk("f2000_pad40", 64'(fbuf[(nfr - 1) % 4][40]), 64'h28);

    // Continuous mode, 12-cycle gaps, three frames.
    base = nfr;
    fl = int'($urandom_range(60, 140)); ad = int'($urandom_range(1, 4));
    frame_len = 14'(fl); gap_len = 16'd12; ack_delay = ad;
    @(negedge tx_clk); continuous = 1'b1;
    wait_frames(base + 3, "cont");
    continuous = 1'b0;
    wait_idle("cont");
    tick(3);
    chk("cont_count", 64'(nfr - base), 64'd3);
    for (int j = 0; j < 3; j++) check_frame(base + j, fl, exp_seq + 32'(j), ad, "cont");
    chk("cont_gap1", 64'(fgap[(base + 1) % 4]), 64'd12);
    chk("cont_gap2", 64'(fgap[(base + 2) % 4]), 64'd12);
    exp_seq += 3; exp_fc += 3;
    chk("cont_frame_count", 64'(frame_count), 64'(exp_fc));

    // gap_len 0, continuous dropped in the middle of the second frame.
    base = nfr;
    frame_len = 14'd70; gap_len = 16'd0; ack_delay = 2;
    @(negedge tx_clk); continuous = 1'b1;
    wait_frames(base + 1, "gap0");
    wait_rise("gap0");
    wait_bytes(10);
    continuous = 1'b0;
    wait_idle("gap0");
    tick(20);
    chk("gap0_count", 64'(nfr - base), 64'd2);
    chk("gap0_gap", 64'(fgap[(base + 1) % 4]), 64'd1);
    check_frame(base + 1, 70, exp_seq + 32'd1, 2, "gap0_f2");
    exp_seq += 2; exp_fc += 2;

    // start pulsed during DATA is ignored.
    base = nfr;
    frame_len = 14'd200; ack_delay = 2;
    pulse_start();
    wait_rise("ign");
    wait_bytes(50);
    pulse_start();
    wait_idle("ign");
    tick(30);
    chk("ign_count", 64'(nfr - base), 64'd1);
    check_frame(base, 200, exp_seq, 2, "ign");
    exp_seq++; exp_fc++;
    chk("ign_frame_count", 64'(frame_count), 64'(exp_fc));

    // Randomized single frames.
    for (int r = 0; r < 3; r++) begin
      run_single(int'($urandom_range(1, 2100)), int'($urandom_range(1, 6)), $sformatf("rnd%0d", r));
    end

    // Asynchronous reset at byte 30.
    frame_len = 14'd100; ack_delay = 2;
    pulse_start();
    wait_rise("rst");
    wait_bytes(31);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_dvld", 64'(mac.mac_tx_dvld), 64'd0);
    chk("rst_counts", {sent_timestamp, frame_count}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    exp_seq = 32'd0; exp_fc = 32'd0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Ack never arrives: abort after 1023 waiting cycles.
    base = nfr; na = n_abort;
    ack_delay = 0;
    pulse_start();
    begin
      int bud;
      bud = 0;
      while (n_abort == na && bud < 2000) begin @(negedge tx_clk); bud++; end
    end
    tick(2);
    chk("to_abort", 64'(n_abort - na), 64'd1);
    chk("to_dvld_cycles", 64'(last_dvc), 64'd1023);
    chk("to_dvld", 64'(mac.mac_tx_dvld), 64'd0);
    chk("to_frame_count", 64'(frame_count), 64'd0);
    chk("to_no_frame", 64'(nfr - base), 64'd0);

    // Next frame still carries sequence 0.
    run_single(80, 3, "post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
